// File: rtl/moving_average_ctrl_pkg.sv
// ============================================================================
// Module  : moving_average_ctrl_pkg
// Brief   : Shared widths, width helpers and sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package moving_average_ctrl_pkg;

    localparam int SIZE_MAX_WINDOW_DEF = 64;

    function automatic int f_w_win(input int max_win);
        return $clog2(max_win) + 1;
    endfunction

    function automatic int f_w_sh(input int max_win);
        return $clog2($clog2(max_win) + 1);
    endfunction

    localparam int W_WIN = f_w_win(SIZE_MAX_WINDOW_DEF);
    localparam int W_SH  = f_w_sh(SIZE_MAX_WINDOW_DEF);

    typedef enum logic [1:0] {
        MA_CLEAR = 2'd0,
        MA_FILL  = 2'd1,
        MA_RUN   = 2'd2
    } ma_state_t;

endpackage

`default_nettype wire

// File: rtl/moving_average_ctrl_window_check.sv
// ============================================================================
// Module  : ma_window_check
// Brief   : Combinational legality check and log2 of a requested window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_window_check
    import moving_average_ctrl_pkg::*;
#(
    parameter int SIZE_MAX_WINDOW = 64
) (
    input  logic [f_w_win(SIZE_MAX_WINDOW)-1:0] i_cfg_window,
    output logic                                o_legal,
    output logic [f_w_sh(SIZE_MAX_WINDOW)-1:0]  o_shift
);

    localparam int C_W_WIN = f_w_win(SIZE_MAX_WINDOW);
    localparam int C_W_SH  = f_w_sh(SIZE_MAX_WINDOW);
    localparam logic [C_W_WIN-1:0] C_MAX = C_W_WIN'(SIZE_MAX_WINDOW);

    logic [C_W_WIN-1:0] w_minus_one;
    logic               w_one_hot;

    always_comb begin
        w_minus_one = i_cfg_window - C_W_WIN'(1);
        w_one_hot   = (i_cfg_window != '0) && ((i_cfg_window & w_minus_one) == '0);
        o_legal     = w_one_hot && (i_cfg_window <= C_MAX);
        o_shift     = '0;
        for (int i = 0; i < C_W_WIN; i++) begin
            if (i_cfg_window[i]) begin
                o_shift = C_W_SH'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/moving_average_ctrl.sv
// ============================================================================
// Module  : moving_average_ctrl
// Brief   : Run-time sequencer (CLEAR/FILL/RUN) for the moving-average datapath.
//           Optional drop counter enabled by defining MA_CTRL_DROP_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module moving_average_ctrl
    import moving_average_ctrl_pkg::*;
#(
    parameter int SIZE_MAX_WINDOW = 64,
    parameter int SIZE_WINDOW     = 8,
    parameter int CLEAR_CYCLES    = SIZE_MAX_WINDOW
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cfg_valid,
    input  logic [f_w_win(SIZE_MAX_WINDOW)-1:0] cfg_window,
    output logic                                cfg_ready,
    output logic                                cfg_err,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                ma_enable,
    output logic                                ma_clear,
    output logic [f_w_win(SIZE_MAX_WINDOW)-1:0] ma_window,
    output logic [f_w_sh(SIZE_MAX_WINDOW)-1:0]  ma_shift,
    output logic                                ma_avg_gate
`ifdef MA_CTRL_DROP_COUNT_EN
    ,
    output logic [15:0]                         drop_count
`endif
);

    localparam int C_W_WIN = f_w_win(SIZE_MAX_WINDOW);
    localparam int C_W_SH  = f_w_sh(SIZE_MAX_WINDOW);
    localparam int C_CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [C_CLR_W-1:0] C_CLR_LAST = C_CLR_W'(CLEAR_CYCLES - 1);

    ma_state_t          r_state;
    logic [C_CLR_W-1:0] r_clear_cnt;
    logic [C_W_WIN-1:0] r_fill_cnt;
    logic [C_W_WIN-1:0] r_window;
    logic [C_W_SH-1:0]  r_shift;
    logic               r_ma_clear;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic               r_avg_gate;

    logic               w_legal;
    logic [C_W_SH-1:0]  w_shift;
    logic               w_accept;
    logic               w_restart;
    logic [C_W_WIN-1:0] w_fill_next;

    ma_window_check #(
        .SIZE_MAX_WINDOW (SIZE_MAX_WINDOW)
    ) u_window_check (
        .i_cfg_window (cfg_window),
        .o_legal      (w_legal),
        .o_shift      (w_shift)
    );

    // An illegal request alone changes nothing; a coincident flush still restarts.
    assign w_accept    = cfg_valid & r_cfg_ready;
    assign w_restart   = (w_accept & w_legal) | (flush & (r_state != MA_CLEAR));
    assign w_fill_next = r_fill_cnt + C_W_WIN'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= MA_CLEAR;
            r_clear_cnt <= '0;
            r_fill_cnt  <= '0;
            r_window    <= C_W_WIN'(SIZE_WINDOW);
            r_shift     <= C_W_SH'($clog2(SIZE_WINDOW));
            r_ma_clear  <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_avg_gate  <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_window <= cfg_window;
                r_shift  <= w_shift;
            end
            if (w_restart) begin
                r_state     <= MA_CLEAR;
                r_clear_cnt <= '0;
                r_fill_cnt  <= '0;
                r_ma_clear  <= 1'b1;
                r_cfg_ready <= 1'b0;
                r_avg_gate  <= 1'b0;
            end else begin
                case (r_state)
                    MA_CLEAR: begin
                        if (r_clear_cnt == C_CLR_LAST) begin
                            r_state     <= MA_FILL;
                            r_fill_cnt  <= '0;
                            r_ma_clear  <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end else begin
                            r_clear_cnt <= r_clear_cnt + C_CLR_W'(1);
                        end
                    end
                    MA_FILL: begin
                        if (in_valid) begin
                            if (w_fill_next == r_window) begin
                                r_state    <= MA_RUN;
                                r_avg_gate <= 1'b1;
                            end else begin
                                r_fill_cnt <= w_fill_next;
                            end
                        end
                    end
                    MA_RUN: begin
                    end
                    default: begin
                        r_state     <= MA_CLEAR;
                        r_clear_cnt <= '0;
                        r_ma_clear  <= 1'b1;
                        r_cfg_ready <= 1'b0;
                        r_avg_gate  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MA_CTRL_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_accept && w_legal) begin
            r_drop_count <= '0;
        end else if (in_valid && (r_state == MA_CLEAR) && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign ma_enable   = in_valid & (r_state != MA_CLEAR);
    assign ma_clear    = r_ma_clear;
    assign cfg_ready   = r_cfg_ready;
    assign cfg_err     = r_cfg_err;
    assign ma_window   = r_window;
    assign ma_shift    = r_shift;
    assign ma_avg_gate = r_avg_gate;

endmodule

`default_nettype wire
